// File: rtl/aqua_pkg.sv
// Shared definitions for the vending change path: coin values in change units
// (1 unit = 5 Rs) and the change_dispenser state/coin encodings.
package aqua_pkg;

   localparam int unsigned COIN5_UNITS  = 1;
   localparam int unsigned COIN10_UNITS = 2;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SELECT,
      ST_EJECT,
      ST_WAIT_SENSE,
      ST_GAP,
      ST_DONE,
      ST_FAULT
   } disp_state_e;

   typedef enum logic {
      COIN_5  = 1'b0,
      COIN_10 = 1'b1
   } coin_e;

   // Value of one coin of the given type, in change units.
   function automatic int unsigned coin_units(input coin_e coin);
      return (coin == COIN_10) ? COIN10_UNITS : COIN5_UNITS;
   endfunction

endpackage

// File: rtl/eject_timer.sv
// Loadable down-counter; expired_c is high whenever the count has reached zero.
module eject_timer #(
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   output logic             expired_c
);

   logic [CNT_W-1:0] count;

   // Load wins over counting; the counter parks at zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (count != '0) begin
         count <= count - CNT_W'(1);
      end
   end

   assign expired_c = (count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Pays out owed change one coin at a time from a 10 Rs and a 5 Rs hopper,
// confirming each drop on the exit sensor with bounded retries before faulting.
module change_dispenser #(
   parameter int unsigned AMT_W         = 4,
   parameter int unsigned SENSE_TIMEOUT = 50,
   parameter int unsigned GAP_CYCLES    = 4,
   parameter int unsigned MAX_RETRY     = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req_valid,
   input  logic [AMT_W-1:0] req_amount,
   output logic             req_ready,
   output logic             eject10,
   output logic             eject5,
   input  logic             sense10,
   input  logic             sense5,
   input  logic             empty10,
   input  logic             empty5,
   output logic             done,
   output logic             fault,
   input  logic             fault_clr,
   output logic [AMT_W-1:0] owed
);

   import aqua_pkg::*;

   localparam int unsigned TMR_MAX = (SENSE_TIMEOUT > GAP_CYCLES) ? SENSE_TIMEOUT : GAP_CYCLES;
   localparam int unsigned TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   disp_state_e        state, state_nxt;
   coin_e              coin, coin_nxt;
   logic [AMT_W-1:0]   owed_nxt;
   logic [RETRY_W-1:0] retry, retry_nxt;
   logic               req_ready_nxt, eject10_nxt, eject5_nxt, done_nxt, fault_nxt;

   logic               tmr_load_c;
   logic [TMR_W-1:0]   tmr_val_c;
   logic               tmr_expired_c;
   logic               sense_sel_c;
   logic [AMT_W-1:0]   units_c;

   // One timer serves both the sense window and the inter-coin settle gap.
   eject_timer #(
      .CNT_W(TMR_W)
   ) u_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (tmr_load_c),
      .load_val (tmr_val_c),
      .expired_c(tmr_expired_c)
   );

   // Only the hopper that was just fired can confirm a coin.
   assign sense_sel_c = (coin == COIN_10) ? sense10 : sense5;
   assign units_c     = AMT_W'(coin_units(coin));

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         coin      <= COIN_5;
         owed      <= '0;
         retry     <= '0;
         req_ready <= 1'b0;
         eject10   <= 1'b0;
         eject5    <= 1'b0;
         done      <= 1'b0;
         fault     <= 1'b0;
      end else begin
         state     <= state_nxt;
         coin      <= coin_nxt;
         owed      <= owed_nxt;
         retry     <= retry_nxt;
         req_ready <= req_ready_nxt;
         eject10   <= eject10_nxt;
         eject5    <= eject5_nxt;
         done      <= done_nxt;
         fault     <= fault_nxt;
      end
   end

   // Next state, datapath updates and next registered outputs.
   always_comb begin
      state_nxt  = state;
      coin_nxt   = coin;
      owed_nxt   = owed;
      retry_nxt  = retry;
      tmr_load_c = 1'b0;
      tmr_val_c  = '0;

      case (state)
         ST_IDLE: begin
            if (req_valid && req_ready) begin
               owed_nxt  = req_amount;
               retry_nxt = '0;
               state_nxt = (req_amount == '0) ? ST_DONE : ST_SELECT;
            end
         end

         ST_SELECT: begin
            // Greedy: 10 Rs whenever at least two units remain and it is stocked.
            if (owed == '0) begin
               state_nxt = ST_DONE;
            end else if ((owed >= AMT_W'(COIN10_UNITS)) && !empty10) begin
               coin_nxt  = COIN_10;
               state_nxt = ST_EJECT;
            end else if (!empty5) begin
               coin_nxt  = COIN_5;
               state_nxt = ST_EJECT;
            end else begin
               state_nxt = ST_FAULT;
            end
         end

         ST_EJECT: begin
            tmr_load_c = 1'b1;
            tmr_val_c  = TMR_W'(SENSE_TIMEOUT - 1);
            state_nxt  = ST_WAIT_SENSE;
         end

         ST_WAIT_SENSE: begin
            // A sense on the expiry cycle still counts the coin.
            if (sense_sel_c) begin
               owed_nxt   = (owed > units_c) ? (owed - units_c) : '0;
               retry_nxt  = '0;
               tmr_load_c = 1'b1;
               tmr_val_c  = TMR_W'(GAP_CYCLES - 1);
               state_nxt  = ST_GAP;
            end else if (tmr_expired_c) begin
               if (retry < RETRY_W'(MAX_RETRY)) begin
                  retry_nxt = retry + RETRY_W'(1);
                  state_nxt = ST_EJECT;
               end else begin
                  state_nxt = ST_FAULT;
               end
            end
         end

         ST_GAP: begin
            if (tmr_expired_c) begin
               state_nxt = ST_SELECT;
            end
         end

         ST_DONE: begin
            owed_nxt  = '0;
            state_nxt = ST_IDLE;
         end

         ST_FAULT: begin
            if (fault_clr) begin
               owed_nxt  = '0;
               retry_nxt = '0;
               state_nxt = ST_IDLE;
            end
         end

         default: begin
            state_nxt = ST_IDLE;
         end
      endcase

      req_ready_nxt = (state_nxt == ST_IDLE);
      eject10_nxt   = (state_nxt == ST_EJECT) && (coin_nxt == COIN_10);
      eject5_nxt    = (state_nxt == ST_EJECT) && (coin_nxt == COIN_5);
      done_nxt      = (state_nxt == ST_DONE);
      fault_nxt     = (state_nxt == ST_FAULT);
   end

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed and randomized payouts checked against a
// cycle-level event model built from greedy coin selection and hopper timing.
module tb_change_dispenser;

   localparam int unsigned AMT_W = 4;
   localparam int          ST    = 50;
   localparam int          GAP   = 4;
   localparam int          MAXR  = 2;

   localparam int K_E10   = 1;
   localparam int K_E5    = 2;
   localparam int K_DONE  = 3;
   localparam int K_FAULT = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic             req_valid;
   logic [AMT_W-1:0] req_amount;
   logic             req_ready;
   logic             eject10, eject5;
   logic             sense10, sense5;
   logic             empty10, empty5;
   logic             done, fault, fault_clr;
   logic [AMT_W-1:0] owed;

   int n_asrt = 0;
   int n_fail = 0;
   int cyc    = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   change_dispenser #(
      .AMT_W        (AMT_W),
      .SENSE_TIMEOUT(ST),
      .GAP_CYCLES   (GAP),
      .MAX_RETRY    (MAXR)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .req_valid (req_valid),
      .req_amount(req_amount),
      .req_ready (req_ready),
      .eject10   (eject10),
      .eject5    (eject5),
      .sense10   (sense10),
      .sense5    (sense5),
      .empty10   (empty10),
      .empty5    (empty5),
      .done      (done),
      .fault     (fault),
      .fault_clr (fault_clr),
      .owed      (owed)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asrt++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s at cycle %0d: observed %0d, expected %0d", tag, cyc, obs, exp);
      end
   endtask

   // Greedy payout rule: what the dispenser should do next with rem units owed.
   function automatic int choose(input int rem, input logic e10, input logic e5);
      if (rem == 0) return K_DONE;
      if (rem >= 2 && !e10) return K_E10;
      if (!e5) return K_E5;
      return K_FAULT;
   endfunction

   function automatic int rand_dly();
      case ($urandom_range(4))
         0:       return ST;
         1:       return 1;
         default: return int'($urandom_range(8, 2));
      endcase
   endfunction

   function automatic int rand_lose();
      int r;
      r = int'($urandom_range(9));
      return (r < 7) ? 0 : r - 6;
   endfunction

   // One transaction: request amt units, play the hoppers, check every cycle.
   task automatic pay(input int amt, input logic e10_i, input logic e5_i,
                      input int dly_fix, input int lose_fix, input bit strays);
      int evt, kind, rem, owed_vis, upd_at, sense_at, att, lose_n, dly, last_ej, last_sense;
      bit cur10, finished, ok;
      empty10 = e10_i;
      empty5  = e5_i;
      ok = 1'b0;
      for (int i = 0; i < 20 && !ok; i++) begin
         if (req_ready === 1'b1) ok = 1'b1;
         else tick();
      end
      chk("ready_before_req", 32'(ok), 32'd1);

      req_valid  = 1'b1;
      req_amount = AMT_W'(amt);
      tick();
      req_valid = 1'b0;

      rem = amt; owed_vis = amt; upd_at = -1; sense_at = -1; att = 0;
      last_ej = -100; last_sense = -100; cur10 = 1'b0; finished = 1'b0;
      lose_n = (lose_fix >= 0) ? lose_fix : rand_lose();
      dly    = (dly_fix > 0) ? dly_fix : rand_dly();
      if (amt == 0) begin
         evt = 1; kind = K_DONE;
      end else begin
         evt = 2; kind = choose(rem, empty10, empty5);
      end

      for (int c = 1; c <= 3000; c++) begin
         if (c == upd_at) owed_vis = rem;
         chk("eject10",   32'(eject10),   32'(c == evt && kind == K_E10));
         chk("eject5",    32'(eject5),    32'(c == evt && kind == K_E5));
         chk("done",      32'(done),      32'(c == evt && kind == K_DONE));
         chk("fault",     32'(fault),     32'(c == evt && kind == K_FAULT));
         chk("req_ready", 32'(req_ready), 32'd0);
         chk("owed",      32'(owed),      32'(owed_vis));
         sense10 = 1'b0; sense5 = 1'b0; req_valid = 1'b0;

         if (c == evt) begin
            if (kind == K_DONE || kind == K_FAULT) begin
               finished = 1'b1;
               break;
            end
            cur10   = (kind == K_E10);
            last_ej = c;
            if (att < lose_n) begin
               evt = c + ST + 1;
               if (att >= MAXR) kind = K_FAULT;
               att++;
            end else begin
               sense_at = c + dly;
               evt = -1;
            end
         end

         if (c == sense_at) begin
            if (cur10) sense10 = 1'b1;
            else sense5 = 1'b1;
            rem = rem - (cur10 ? 2 : 1);
            if (rem < 0) rem = 0;
            upd_at = c + 1; last_sense = c; sense_at = -1; att = 0;
            if (strays && $urandom_range(3) == 0) empty10 = ~empty10;
            if (strays && $urandom_range(3) == 0) empty5 = ~empty5;
            lose_n = (lose_fix >= 0) ? 0 : rand_lose();
            dly    = (dly_fix > 0) ? dly_fix : rand_dly();
            kind   = choose(rem, empty10, empty5);
            evt    = c + GAP + 2;
         end else if (strays) begin
            if (c > last_sense && c <= last_sense + GAP) begin
               sense10 = ($urandom_range(2) == 0);
               sense5  = ($urandom_range(2) == 0);
               if ($urandom_range(3) == 0) begin
                  req_valid  = 1'b1;
                  req_amount = AMT_W'($urandom);
               end
            end else if (c > last_ej && (evt < 0 || c < evt) && $urandom_range(3) == 0) begin
               if (cur10) sense5 = 1'b1;
               else sense10 = 1'b1;
            end
         end
         tick();
      end
      sense10 = 1'b0; sense5 = 1'b0; req_valid = 1'b0;
      chk("payout_finished", 32'(finished), 32'd1);

      if (finished && kind == K_DONE) begin
         tick();
         chk("idle_ready", 32'(req_ready), 32'd1);
         chk("idle_done",  32'(done),      32'd0);
         chk("idle_owed",  32'(owed),      32'd0);
      end else if (finished) begin
         for (int h = 0; h < 3; h++) begin
            sense10   = ($urandom_range(1) == 0);
            sense5    = ($urandom_range(1) == 0);
            req_valid = ($urandom_range(1) == 0);
            tick();
            chk("fault_hold",    32'(fault),     32'd1);
            chk("fault_ready",   32'(req_ready), 32'd0);
            chk("fault_eject10", 32'(eject10),   32'd0);
            chk("fault_eject5",  32'(eject5),    32'd0);
            chk("fault_owed",    32'(owed),      32'(owed_vis));
         end
         sense10 = 1'b0; sense5 = 1'b0; req_valid = 1'b0;
         fault_clr = 1'b1;
         tick();
         fault_clr = 1'b0;
         chk("clr_fault", 32'(fault),     32'd0);
         chk("clr_ready", 32'(req_ready), 32'd1);
         chk("clr_owed",  32'(owed),      32'd0);
      end
   endtask

   initial begin
      reset = 1'b0; req_valid = 1'b0; req_amount = '0; sense10 = 1'b0; sense5 = 1'b0;
      empty10 = 1'b0; empty5 = 1'b0; fault_clr = 1'b0;
      tick(); tick();
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_ej10",  32'(eject10),   32'd0);
      chk("rst_ej5",   32'(eject5),    32'd0);
      chk("rst_done",  32'(done),      32'd0);
      chk("rst_fault", 32'(fault),     32'd0);
      chk("rst_owed",  32'(owed),      32'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      chk("post_rst_ready", 32'(req_ready), 32'd1);
      chk("post_rst_owed",  32'(owed),      32'd0);

      pay(5, 1'b0, 1'b0, 3, 0, 1'b0);    // 10,10,5
      pay(3, 1'b1, 1'b0, 3, 0, 1'b0);    // 5,5,5 with 10 Rs hopper empty
      pay(2, 1'b0, 1'b0, 3, 3, 1'b0);    // sense never arrives -> fault
      pay(1, 1'b0, 1'b1, 3, 0, 1'b0);    // 5 Rs empty -> fault at select
      pay(3, 1'b1, 1'b1, 3, 0, 1'b0);    // both empty
      pay(2, 1'b0, 1'b0, ST, 0, 1'b1);   // sense on expiry cycle, strays
      pay(4, 1'b0, 1'b0, ST, 1, 1'b1);   // one lost coin, then sense on expiry
      pay(0, 1'b0, 1'b0, 1, 0, 1'b0);
      pay(15, 1'b0, 1'b0, 2, 0, 1'b1);

      // Reset in the middle of a sense wait.
      empty10 = 1'b0; empty5 = 1'b0;
      req_valid = 1'b1; req_amount = AMT_W'(3);
      tick();
      req_valid = 1'b0;
      tick();
      chk("mid_eject10", 32'(eject10), 32'd1);
      tick(); tick();
      chk("mid_owed", 32'(owed), 32'd3);
      reset = 1'b0;
      #1;
      chk("mid_rst_ready", 32'(req_ready), 32'd0);
      chk("mid_rst_ej10",  32'(eject10),   32'd0);
      chk("mid_rst_ej5",   32'(eject5),    32'd0);
      chk("mid_rst_done",  32'(done),      32'd0);
      chk("mid_rst_fault", 32'(fault),     32'd0);
      chk("mid_rst_owed",  32'(owed),      32'd0);
      tick();
      chk("mid_rst_hold_ej10", 32'(eject10), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      tick();
      chk("mid_post_ready", 32'(req_ready), 32'd1);
      chk("mid_post_owed",  32'(owed),      32'd0);
      pay(0, 1'b0, 1'b0, 1, 0, 1'b0);

      for (int t = 0; t < 30; t++) begin
         pay(int'($urandom_range(15)), ($urandom_range(4) == 0), ($urandom_range(4) == 0), 0, -1, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
      $finish;
   end

endmodule
